// File: rtl/jt1942_snd_pkg.sv
// Shared constants and helpers for the 1942 sound output filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jt1942_snd_pkg;

  localparam int SND_W          = 9;   // width of the mixed AY sum from the sound board
  localparam int DEF_DECIM_LOG2 = 5;   // 1.5 MHz / 32 = 46.875 kHz output rate
  localparam int DEF_DC_SHIFT   = 10;  // DC tracker time constant, in output samples (log2)
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_BW         = SND_W + DEF_DECIM_LOG2;

  // Unsigned accumulator plus signed step, clamped to [0, 2^w - 1].
  // Operands are carried at 64 bits so one helper serves every width up to 63.
  function automatic logic [63:0] sat_add_u(input logic [63:0]        a,
                                            input logic signed [63:0] b,
                                            input int unsigned        w);
    logic signed [65:0] sum;
    logic signed [65:0] lim;
    sum = $signed({2'b00, a}) + 66'(b);
    lim = (66'sd1 <<< w) - 66'sd1;
    if (sum[65])
      return '0;
    else if (sum > lim)
      return lim[63:0];
    else
      return sum[63:0];
  endfunction

endpackage

// File: rtl/jt1942_snd_filter_if.sv
// Sound filter stream bundle: raw AY sum in, DC-free PCM sample out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take every sample_stb.
interface jt1942_snd_filter_if
  import jt1942_snd_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
);
  logic                    cen1p5;
  logic [SND_W-1:0]        snd_in;
  logic                    mute;
  logic signed [OUT_W-1:0] sample;
  logic                    sample_stb;

  // Sound board side drives the raw samples; the filter drives the PCM result.
  modport master (output cen1p5, snd_in, mute, input sample, sample_stb);
  modport slave  (input cen1p5, snd_in, mute, output sample, sample_stb);

endinterface

// File: rtl/jt1942_dcblock.sv
// Leaky-integrator DC remover on decimated boxcar sums, with output register and mute.
// Latency: sample/sample_stb register one clk after box_vld.
// Backpressure: none; every box_vld yields one sample_stb.
module jt1942_dcblock
  import jt1942_snd_pkg::*;
#(
  parameter int BW       = DEF_BW,
  parameter int DC_SHIFT = DEF_DC_SHIFT,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BW-1:0]           box,
  input  logic                    box_vld,
  input  logic                    mute,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_stb
);

  localparam int DW = BW + DC_SHIFT;     // tracker keeps DC_SHIFT fraction bits
  localparam int SH = OUT_W - BW - 1;    // left-justify hp into the output word

  logic [DW-1:0]           dc;
  logic                    primed;
  logic [BW-1:0]           dc_int;
  logic signed [BW:0]      hp;
  logic signed [BW:0]      hp_eff;
  logic signed [OUT_W-1:0] hp_ext;
  logic [DW-1:0]           dc_nxt;

  assign dc_int = dc[DW-1 -: BW];
  assign hp     = $signed({1'b0, box}) - $signed({1'b0, dc_int});
  // Until the tracker has seen one box it holds no estimate, so emit silence
  // rather than the full box value (avoids a power-on click).
  assign hp_eff = primed ? hp : '0;
  assign hp_ext = OUT_W'(hp_eff);
  // dc moves by hp per sample, i.e. dc_int moves by hp / 2^DC_SHIFT.
  // hp is bounded by the distance to the box, so the clamp never engages
  // in normal operation; it only guards against corrupted state.
  assign dc_nxt = DW'(sat_add_u(64'(dc), 64'(hp), DW));

  // Track DC, register the high-passed sample and its strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc         <= '0;
      primed     <= 1'b0;
      sample     <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= box_vld;
      if (box_vld) begin
        if (!primed) begin
          dc     <= DW'(box) << DC_SHIFT;
          primed <= 1'b1;
        end else begin
          dc <= dc_nxt;
        end
        sample <= mute ? '0 : (hp_ext <<< SH);
      end
    end
  end

endmodule

// File: rtl/jt1942_snd_filter.sv
// 1942 sound output stage: boxcar-decimate the AY sum, strip DC, emit signed PCM.
// Latency: sample_stb one clk after the clk carrying the frame-closing cen1p5.
// Backpressure: none; runs off cen1p5, one strobe per 2^DECIM_LOG2 enables.
module jt1942_snd_filter
  import jt1942_snd_pkg::*;
#(
  parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
  parameter int DC_SHIFT   = DEF_DC_SHIFT,
  parameter int OUT_W      = DEF_OUT_W      // must be at least 9 + DECIM_LOG2 + 1
) (
  input  logic               clk,
  input  logic               rst,
  jt1942_snd_filter_if.slave snd
);

  localparam int BW = SND_W + DECIM_LOG2;  // 2^DECIM_LOG2 * 511 always fits

  logic [DECIM_LOG2-1:0]   cnt;
  logic [BW-1:0]           acc;
  logic [BW-1:0]           acc_sum;
  logic [BW-1:0]           box;
  logic                    box_vld;
  logic signed [OUT_W-1:0] sample_q;
  logic                    stb_q;

  assign acc_sum = acc + BW'(snd.snd_in);

  // Boxcar accumulate on each enable; the last enable of a frame hands the sum
  // to the DC stage and restarts the accumulator from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      box     <= '0;
      box_vld <= 1'b0;
    end else begin
      box_vld <= 1'b0;
      if (snd.cen1p5) begin
        cnt <= cnt + DECIM_LOG2'(1);
        if (&cnt) begin
          box     <= acc_sum;
          acc     <= '0;
          box_vld <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  jt1942_dcblock #(
    .BW       (BW),
    .DC_SHIFT (DC_SHIFT),
    .OUT_W    (OUT_W)
  ) u_dcblock (
    .clk        (clk),
    .rst        (rst),
    .box        (box),
    .box_vld    (box_vld),
    .mute       (snd.mute),
    .sample     (sample_q),
    .sample_stb (stb_q)
  );

  assign snd.sample     = sample_q;
  assign snd.sample_stb = stb_q;

endmodule

// File: tb/tb_jt1942_snd_filter.sv
// Directed bench for the 1942 sound filter: decimation timing, DC removal, mute, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_jt1942_snd_filter;

  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt1942_snd_filter_if #(.OUT_W(OUT_W)) bus();

  jt1942_snd_filter dut (
    .clk (clk),
    .rst (rst),
    .snd (bus)
  );

  int total = 0;
  int bad   = 0;
  int stb_count = 0;

  always @(negedge clk) if (bus.sample_stb === 1'b1) stb_count++;

  // Reference DC tracker (DC_SHIFT=10, 24-bit tracker, output shift 1).
  longint m_dc;
  bit     m_primed;

  task automatic model_frame(input longint box, input bit mu, output logic signed [15:0] exp);
    longint hp;
    hp = box - (m_dc >> 10);
    if (!m_primed) begin
      m_dc = box << 10;
      m_primed = 1'b1;
      hp = 0;
    end else begin
      m_dc = m_dc + hp;
      if (m_dc < 0) m_dc = 0;
      if (m_dc > 64'sd16777215) m_dc = 64'sd16777215;
    end
    exp = mu ? 16'sd0 : 16'(hp * 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cen1p5 = 1'b0;
    bus.mute = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_dc = 0;
    m_primed = 1'b0;
  endtask

  // One enable spanning exactly one rising edge; snd_in is scrambled afterwards.
  task automatic cen_once(input logic [8:0] v);
    bus.cen1p5 = 1'b1;
    bus.snd_in = v;
    @(negedge clk);
    bus.cen1p5 = 1'b0;
    bus.snd_in = ~v;
  endtask

  task automatic run_frame(input logic [8:0] v, input int gap, input bit mu,
                           output logic signed [15:0] got, output logic got_stb);
    bus.mute = mu;
    for (int i = 0; i < 32; i++) begin
      repeat (gap) @(negedge clk);
      cen_once(v);
    end
    @(negedge clk);
    got_stb = bus.sample_stb;
    got = bus.sample;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus.sample !== 16'sd0) begin bad++; $display("FAIL rst_sample: got %0d want 0", bus.sample); end
    total++;
    if (bus.sample_stb !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", bus.sample_stb); end
    rst = 1'b0;
    m_dc = 0;
    m_primed = 1'b0;
  endtask

  task automatic test_prime_and_step();
    logic signed [15:0] got;
    logic s;
    int c0;
    do_reset();
    c0 = stb_count;
    run_frame(9'h100, 15, 1'b0, got, s);
    total++;
    if (s !== 1'b1) begin bad++; $display("FAIL t1_stb1: got %b want 1", s); end
    total++;
    if (got !== 16'sd0) begin bad++; $display("FAIL t1_prime: got %0d want 0", got); end
    @(negedge clk); #1;
    total++;
    if (bus.sample_stb !== 1'b0) begin bad++; $display("FAIL t1_pulse_width: got %b want 0", bus.sample_stb); end
    total++;
    if (stb_count - c0 !== 1) begin bad++; $display("FAIL t1_stb_count: got %0d want 1", stb_count - c0); end
    run_frame(9'h100, 15, 1'b0, got, s);
    total++;
    if (s !== 1'b1 || got !== 16'sd0) begin bad++; $display("FAIL t1_flat: got stb=%b %0d want stb=1 0", s, got); end
    run_frame(9'h180, 15, 1'b0, got, s);
    total++;
    if (s !== 1'b1 || got !== 16'sd8192) begin bad++; $display("FAIL t2_step: got stb=%b %0d want stb=1 8192", s, got); end
    run_frame(9'h180, 15, 1'b0, got, s);
    total++;
    if (s !== 1'b1 || got !== 16'sd8184) begin bad++; $display("FAIL t2_decay: got stb=%b %0d want stb=1 8184", s, got); end
    repeat (5) @(negedge clk);
    total++;
    if (bus.sample !== 16'sd8184 || bus.sample_stb !== 1'b0) begin
      bad++; $display("FAIL t2_hold: got stb=%b %0d want stb=0 8184", bus.sample_stb, bus.sample);
    end
  endtask

  task automatic test_full_scale();
    logic signed [15:0] got;
    logic s;
    logic signed [15:0] want [4];
    want = '{16'sd32704, 16'sd32674, 16'sd32642, 16'sd32610};
    do_reset();
    run_frame(9'h000, 3, 1'b0, got, s);
    total++;
    if (s !== 1'b1 || got !== 16'sd0) begin bad++; $display("FAIL t3_prime0: got stb=%b %0d want stb=1 0", s, got); end
    for (int k = 0; k < 4; k++) begin
      run_frame(9'h1FF, 3, 1'b0, got, s);
      total++;
      if (s !== 1'b1 || got !== want[k]) begin
        bad++; $display("FAIL t3_full_%0d: got stb=%b %0d want stb=1 %0d", k, s, got, want[k]);
      end
    end
  endtask

  task automatic test_mute();
    logic signed [15:0] got;
    logic signed [15:0] exp;
    logic s;
    bit mu;
    logic [8:0] v;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      mu = (k >= 2 && k < 6);
      v = (k % 2 == 1) ? 9'h1FF : 9'h000;
      model_frame(longint'(v) * 32, mu, exp);
      run_frame(v, 3, mu, got, s);
      total++;
      if (s !== 1'b1 || got !== exp) begin
        bad++; $display("FAIL t4_mute_%0d: got stb=%b %0d want stb=1 %0d", k, s, got, exp);
      end
    end
    bus.mute = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic signed [15:0] got;
    logic s;
    int c0;
    do_reset();
    run_frame(9'h100, 2, 1'b0, got, s);
    run_frame(9'h1FF, 2, 1'b0, got, s);
    total++;
    if (s !== 1'b1 || got !== 16'sd16320) begin bad++; $display("FAIL t5_pre: got stb=%b %0d want stb=1 16320", s, got); end
    for (int i = 0; i < 17; i++) begin
      repeat (2) @(negedge clk);
      cen_once(9'h1FF);
    end
    total++;
    if (bus.sample !== 16'sd16320) begin bad++; $display("FAIL t5_hold: got %0d want 16320", bus.sample); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.sample !== 16'sd0) begin bad++; $display("FAIL t5_async_sample: got %0d want 0", bus.sample); end
    total++;
    if (bus.sample_stb !== 1'b0) begin bad++; $display("FAIL t5_async_stb: got %b want 0", bus.sample_stb); end
    @(negedge clk);
    rst = 1'b0;
    c0 = stb_count;
    for (int i = 0; i < 31; i++) begin
      repeat (2) @(negedge clk);
      cen_once(9'h1FF);
    end
    @(negedge clk); #1;
    total++;
    if (stb_count !== c0) begin bad++; $display("FAIL t5_early_stb: got %0d strobes want 0", stb_count - c0); end
    cen_once(9'h1FF);
    @(negedge clk);
    total++;
    if (bus.sample_stb !== 1'b1 || bus.sample !== 16'sd0) begin
      bad++; $display("FAIL t5_first: got stb=%b %0d want stb=1 0", bus.sample_stb, bus.sample);
    end
  endtask

  task automatic test_irregular();
    logic signed [15:0] exp;
    longint acc;
    int c0;
    int ncen;
    int g;
    logic [8:0] v;
    do_reset();
    c0 = stb_count;
    ncen = 0;
    for (int f = 0; f < 4; f++) begin
      acc = 0;
      for (int i = 0; i < 32; i++) begin
        g = $urandom_range(1, 40);
        for (int k = 0; k < g - 1; k++) begin
          @(negedge clk);
          bus.snd_in = 9'($urandom);
        end
        v = 9'($urandom_range(0, 511));
        cen_once(v);
        acc += v;
        ncen++;
      end
      model_frame(acc, 1'b0, exp);
      @(negedge clk);
      total++;
      if (bus.sample_stb !== 1'b1 || bus.sample !== exp) begin
        bad++; $display("FAIL t6_frame_%0d: got stb=%b %0d want stb=1 %0d", f, bus.sample_stb, bus.sample, exp);
      end
    end
    @(negedge clk); #1;
    total++;
    if (stb_count - c0 !== ncen / 32) begin
      bad++; $display("FAIL t6_stb_count: got %0d want %0d", stb_count - c0, ncen / 32);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = stb_count;
    for (int i = 0; i < 64; i++) cen_once(9'h100);
    @(negedge clk);
    total++;
    if (bus.sample_stb !== 1'b1 || bus.sample !== 16'sd0) begin
      bad++; $display("FAIL btb_flat: got stb=%b %0d want stb=1 0", bus.sample_stb, bus.sample);
    end
    #1;
    total++;
    if (stb_count - c0 !== 2) begin bad++; $display("FAIL btb_count: got %0d want 2", stb_count - c0); end
    for (int i = 0; i < 32; i++) cen_once(9'h180);
    @(negedge clk);
    total++;
    if (bus.sample_stb !== 1'b1 || bus.sample !== 16'sd8192) begin
      bad++; $display("FAIL btb_step: got stb=%b %0d want stb=1 8192", bus.sample_stb, bus.sample);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cen1p5 = 1'b0;
    bus.snd_in = '0;
    bus.mute = 1'b0;
    m_dc = 0;
    m_primed = 1'b0;
    test_reset();
    test_prime_and_step();
    test_full_scale();
    test_mute();
    test_reset_midframe();
    test_irregular();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
